// File: rtl/keypad_matrix_ctrl_if.sv
// Signal bundle between the keypad scan sequencer and the matrix/downstream logic.
// The master side drives scan enable and the raw rows; the sequencer (slave) drives the rest.
interface keypad_matrix_ctrl_if;
  logic        scan_en;
  logic [2:0]  row_in;
  logic [3:0]  col_out;
  logic [11:0] key_vec;
  logic [11:0] key_out;
  logic        key_valid;
  logic        key_down;
  logic        multi_key;

  modport master (
    output scan_en, row_in,
    input  col_out, key_vec, key_out, key_valid, key_down, multi_key
  );

  modport slave (
    input  scan_en, row_in,
    output col_out, key_vec, key_out, key_valid, key_down, multi_key
  );
endinterface

// File: rtl/keypad_matrix_ctrl.sv
// 4-column x 3-row keypad scanner: column drive, row sampling, frame debounce,
// and a press/release FSM that emits one single-cycle strobe per clean press.
module keypad_matrix_ctrl #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input logic                 clk,
    input logic                 rst,
    keypad_matrix_ctrl_if.slave kp
);

    localparam int              DW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0]   DWELL_MAX = DW'(SCAN_DIV - 1);
    localparam logic [3:0]      DEB       = 4'(DEBOUNCE_SCANS);

    typedef enum logic {IDLE, HELD} state_t;

    logic [2:0]    row_meta, row_s;
    logic [DW-1:0] dwell;
    logic [1:0]    col_idx;
    logic [11:0]   partial, prev_frame, key_vec_r, key_out_r;
    logic [3:0]    stable_cnt, stable_next, ones;
    logic          key_valid_r, multi_key_r;
    logic          sample, frame_end, strobe;
    logic [11:0]   frame, deb_vec;
    state_t        state, state_next;

    function automatic logic [3:0] popcount12(input logic [11:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 12; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= DEB) ? DEB : v + 4'd1;
    endfunction

    // At frame end the column-3 rows are still in row_s, so the frame is assembled here.
    always_comb begin
        sample      = kp.scan_en && (dwell == DWELL_MAX);
        frame_end   = sample && (col_idx == 2'd3);
        frame       = {row_s, partial[8:0]};
        stable_next = (frame == prev_frame) ? sat_inc(stable_cnt) : 4'd1;
        deb_vec     = (stable_next >= DEB) ? frame : key_vec_r;
        ones        = popcount12(deb_vec);
    end

    always_comb begin
        state_next = state;
        strobe     = 1'b0;
        if (frame_end) begin
            unique case (state)
                IDLE: begin
                    if (ones == 4'd1) begin
                        strobe     = 1'b1;
                        state_next = HELD;
                    end else if (ones > 4'd1) begin
                        state_next = HELD;
                    end
                end
                HELD: if (deb_vec == 12'd0) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= 3'd0;
            row_s    <= 3'd0;
        end else begin
            row_meta <= kp.row_in;
            row_s    <= row_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell   <= '0;
            col_idx <= 2'd0;
            partial <= 12'd0;
        end else if (!kp.scan_en) begin
            dwell   <= '0;
            col_idx <= 2'd0;
            partial <= 12'd0;
        end else if (sample) begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
            if (col_idx == 2'd3) partial <= 12'd0;
            else                 partial[col_idx*3 +: 3] <= row_s;
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_frame  <= 12'd0;
            stable_cnt  <= 4'd0;
            key_vec_r   <= 12'd0;
            multi_key_r <= 1'b0;
            key_out_r   <= 12'd0;
            key_valid_r <= 1'b0;
            state       <= IDLE;
        end else begin
            key_valid_r <= strobe;
            key_out_r   <= strobe ? deb_vec : 12'd0;
            state       <= state_next;
            if (frame_end) begin
                prev_frame  <= frame;
                stable_cnt  <= stable_next;
                key_vec_r   <= deb_vec;
                multi_key_r <= (ones > 4'd1);
            end
        end
    end

    assign kp.col_out   = kp.scan_en ? (4'b0001 << col_idx) : 4'b0000;
    assign kp.key_vec   = key_vec_r;
    assign kp.key_out   = key_out_r;
    assign kp.key_valid = key_valid_r;
    assign kp.key_down  = (state == HELD);
    assign kp.multi_key = multi_key_r;

endmodule

// File: tb/tb_keypad_matrix_ctrl.sv
// Directed bench for keypad_matrix_ctrl: a behavioural keypad answers the column drive,
// expected press strobes go into a queue that a separate monitor checks on every key_valid.
module tb_keypad_matrix_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_matrix_ctrl_if kp ();

  keypad_matrix_ctrl #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp)
  );

  typedef struct {
    int          cyc;
    logic [11:0] code;
    logic [11:0] vec;
  } exp_t;

  exp_t        sb[$];
  logic [11:0] keys = 12'd0;
  int          cyc;
  int          total = 0;
  int          bad   = 0;

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  // A pressed key connects its column line to its row line.
  always_comb begin
    kp.row_in = 3'b000;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 3; r++)
        if (kp.col_out[c] && keys[c*3+r]) kp.row_in[r] = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cyc=%0d)", name, act, req, cyc);
    end
  endtask

  task automatic goto(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic push(input int c, input logic [11:0] code);
    exp_t e;
    e.cyc  = c;
    e.code = code;
    e.vec  = code;
    sb.push_back(e);
  endtask

  task automatic check_reset();
    chk("rst_col_out",   kp.col_out,   32'h1);
    chk("rst_key_vec",   kp.key_vec,   32'h0);
    chk("rst_key_out",   kp.key_out,   32'h0);
    chk("rst_key_valid", kp.key_valid, 32'h0);
    chk("rst_key_down",  kp.key_down,  32'h0);
    chk("rst_multi_key", kp.multi_key, 32'h0);
  endtask

  // Monitor: every strobe must match the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && kp.key_valid === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: actual key_out=%0h at cyc=%0d required no pulse", kp.key_out, cyc);
        end else begin
          e = sb.pop_front();
          chk("pulse_cyc",  cyc,         e.cyc);
          chk("pulse_code", kp.key_out,  e.code);
          chk("pulse_vec",  kp.key_vec,  e.vec);
          chk("pulse_down", kp.key_down, 32'h1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    kp.scan_en = 1'b1;
    keys       = 12'd0;
    rst        = 1'b1;
    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b0;

    // Idle scanning: column walks every 4 clocks, nothing reported.
    for (int e = 0; e < 64; e++) begin
      goto(e);
      chk("scan_col_out", kp.col_out, 32'(1 << ((e / 4) % 4)));
    end
    chk("idle_key_vec", kp.key_vec, 32'h0);

    // Key 5 held from reset release: strobe on edge 48.
    @(negedge clk);
    rst  = 1'b1;
    keys = 12'h020;
    @(negedge clk);
    check_reset();
    rst = 1'b0;
    push(48, 12'h020);
    goto(47);
    chk("pre_press_vec",  kp.key_vec,  32'h0);
    chk("pre_press_down", kp.key_down, 32'h0);
    goto(48);
    chk("press_vec",   kp.key_vec,   32'h020);
    chk("press_down",  kp.key_down,  32'h1);
    chk("press_multi", kp.multi_key, 32'h0);
    goto(49);
    chk("post_pulse_valid", kp.key_valid, 32'h0);
    chk("post_pulse_out",   kp.key_out,   32'h0);

    // Release, then press the same key again.
    goto(96);
    keys = 12'h000;
    goto(143);
    chk("rel_pending_vec",  kp.key_vec,  32'h020);
    chk("rel_pending_down", kp.key_down, 32'h1);
    goto(144);
    chk("rel_vec",  kp.key_vec,  32'h0);
    chk("rel_down", kp.key_down, 32'h0);
    keys = 12'h020;
    push(192, 12'h020);
    goto(192);
    chk("repress_down", kp.key_down, 32'h1);

    // Add key 0 while key 5 is held: multi-key, no strobe.
    keys = 12'h021;
    goto(239);
    chk("multi_pending_vec", kp.key_vec,   32'h020);
    chk("multi_pending",     kp.multi_key, 32'h0);
    goto(240);
    chk("multi_vec",  kp.key_vec,   32'h021);
    chk("multi_flag", kp.multi_key, 32'h1);
    chk("multi_down", kp.key_down,  32'h1);
    keys = 12'h000;
    goto(287);
    chk("multi_hold_flag", kp.multi_key, 32'h1);
    goto(288);
    chk("multi_rel_vec",  kp.key_vec,   32'h0);
    chk("multi_rel_flag", kp.multi_key, 32'h0);
    chk("multi_rel_down", kp.key_down,  32'h0);

    // Bounce on alternate frames, then a steady hold.
    for (int k = 0; k < 10; k++) begin
      goto(288 + 16 * k);
      keys = (k % 2 == 0) ? 12'h020 : 12'h000;
    end
    goto(448);
    chk("bounce_vec",  kp.key_vec,  32'h0);
    chk("bounce_down", kp.key_down, 32'h0);
    keys = 12'h020;
    push(496, 12'h020);
    goto(495);
    chk("hold_pending_vec", kp.key_vec, 32'h0);
    goto(496);
    chk("hold_vec", kp.key_vec, 32'h020);

    // Reset mid-frame with the key still held.
    goto(505);
    rst = 1'b1;
    @(negedge clk);
    check_reset();
    rst = 1'b0;
    push(48, 12'h020);
    goto(0);
    chk("restart_col0", kp.col_out, 32'h1);
    goto(4);
    chk("restart_col1", kp.col_out, 32'h2);
    goto(47);
    chk("restart_pending_vec", kp.key_vec, 32'h0);
    goto(48);
    chk("restart_vec", kp.key_vec, 32'h020);

    // Scan disabled mid-frame: no frame ends, so a released key stays reported.
    goto(56);
    kp.scan_en = 1'b0;
    keys       = 12'h000;
    #1;
    chk("disable_col_out", kp.col_out, 32'h0);
    goto(120);
    chk("disabled_col_out", kp.col_out,  32'h0);
    chk("disabled_vec",     kp.key_vec,  32'h020);
    chk("disabled_down",    kp.key_down, 32'h1);
    kp.scan_en = 1'b1;
    keys       = 12'h020;
    #1;
    chk("reenable_col0", kp.col_out, 32'h1);
    goto(124);
    chk("reenable_col1", kp.col_out, 32'h2);
    goto(200);
    chk("reenable_vec",  kp.key_vec,  32'h020);
    chk("reenable_down", kp.key_down, 32'h1);

    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
